// File: rtl/square_rate_estimator.sv
// Runs NUM_ROUNDS square-wave judge rounds, majority-votes the verdicts and converts
// the smallest square edge spacing into a symbol rate with a 32-step restoring divider.
module square_rate_estimator #(
  parameter int          WIDTH_W     = 18,
  parameter int          RATE_W      = 24,
  parameter logic [31:0] CLK_HZ      = 32'd50_000_000,
  parameter int          NUM_ROUNDS  = 4,
  parameter int          VOTE_MIN    = 3,
  parameter int          GAP_CYC     = 16,
  parameter logic [31:0] TIMEOUT_CYC = 32'd10_000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  output logic               judge_start,
  input  logic [WIDTH_W-1:0] judge_width,
  input  logic               judge_square,
  input  logic               judge_dready,
  output logic [RATE_W-1:0]  rate,
  output logic [WIDTH_W-1:0] min_width,
  output logic               is_digital,
  output logic               valid,
  output logic               busy,
  output logic               timeout_err
);

  typedef enum logic [2:0] {IDLE, START, WAIT, GAP, DIVIDE, DONE} state_t;

  localparam logic [31:0] DIVIDEND   = CLK_HZ;
  localparam logic [31:0] RATE_MAX   = 32'((64'd1 << RATE_W) - 64'd1);
  localparam logic [3:0]  LAST_ROUND = 4'(NUM_ROUNDS - 1);
  localparam logic [3:0]  VOTE_THR   = 4'(VOTE_MIN);
  localparam logic [31:0] GAP_LAST   = 32'(GAP_CYC - 1);

  state_t             state, state_nxt;
  logic [3:0]         round_cnt, sq_cnt;
  logic [WIDTH_W-1:0] acc_min;
  logic               err;
  logic [31:0]        tmr, gap_cnt;
  logic [4:0]         div_cnt;
  logic [WIDTH_W:0]   rem, rem_nxt, shifted, divisor;
  logic [31:0]        quot, q_final;
  logic               take, wait_timeout, round_end, last_round, vote_ok, width_ok;
  logic [RATE_W-1:0]  rate_res;

  // The timer already counts the START cycle, so a silent round spans
  // TIMEOUT_CYC cycles from its start pulse to the round's end.
  assign wait_timeout = (state == WAIT) && !judge_dready && (tmr == TIMEOUT_CYC - 32'd1);
  assign round_end    = (state == WAIT) && (judge_dready || wait_timeout);
  assign last_round   = (round_cnt == LAST_ROUND);

  // One restoring-division step, dividend bits MSB first.
  assign shifted = {rem[WIDTH_W-1:0], DIVIDEND[~div_cnt]};
  assign divisor = {1'b0, acc_min};
  assign take    = (shifted >= divisor);
  assign rem_nxt = take ? shifted - divisor : shifted;
  assign q_final = {quot[30:0], take};

  assign vote_ok  = (sq_cnt >= VOTE_THR);
  assign width_ok = (acc_min != '0) && (acc_min != '1);
  assign rate_res = !(vote_ok && width_ok) ? '0 :
                    (q_final > RATE_MAX)   ? '1 : q_final[RATE_W-1:0];

  assign judge_start = (state == START);
  assign busy        = (state != IDLE);
  assign valid       = (state == DONE);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable) state_nxt = START;
      START:   state_nxt = WAIT;
      WAIT:    if (round_end) state_nxt = last_round ? DIVIDE : GAP;
      GAP:     if (gap_cnt == GAP_LAST) state_nxt = START;
      DIVIDE:  if (div_cnt == 5'd31) state_nxt = DONE;
      DONE:    state_nxt = enable ? START : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      round_cnt   <= '0;
      sq_cnt      <= '0;
      acc_min     <= '1;
      err         <= 1'b0;
      tmr         <= '0;
      gap_cnt     <= '0;
      div_cnt     <= '0;
      rem         <= '0;
      quot        <= '0;
      rate        <= '0;
      min_width   <= '1;
      is_digital  <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      tmr     <= (state == START || state == WAIT) ? tmr + 32'd1 : '0;
      gap_cnt <= (state == GAP) ? gap_cnt + 32'd1 : '0;
      div_cnt <= (state == DIVIDE) ? div_cnt + 5'd1 : '0;
      if (state == DIVIDE) begin
        rem  <= rem_nxt;
        quot <= q_final;
      end else begin
        rem  <= '0;
      end
      if ((state == IDLE || state == DONE) && enable) begin
        round_cnt <= '0;
        sq_cnt    <= '0;
        acc_min   <= '1;
        err       <= 1'b0;
      end
      if (round_end) begin
        round_cnt <= round_cnt + 4'd1;
        if (judge_dready && judge_square) begin
          sq_cnt <= sq_cnt + 4'd1;
          if (judge_width < acc_min) acc_min <= judge_width;
        end
        if (!judge_dready) err <= 1'b1;
      end
      if (state == DIVIDE && div_cnt == 5'd31) begin
        rate        <= rate_res;
        min_width   <= acc_min;
        is_digital  <= vote_ok;
        timeout_err <= err;
      end
    end
  end

endmodule

// File: tb/tb_square_rate_estimator.sv
// Directed bench: a behavioural judge answers start pulses; each test checks timing and results.
module tb_square_rate_estimator;
  localparam int GAP = 16;
  localparam int TMO = 10000;

  logic        clk = 1'b0, rst_n = 1'b0, enable = 1'b0;
  logic        judge_start, judge_square = 1'b0, judge_dready = 1'b0;
  logic [17:0] judge_width = '1;
  logic [23:0] rate;
  logic [17:0] min_width;
  logic        is_digital, valid, busy, timeout_err;
  int          checks = 0, errors = 0;

  square_rate_estimator dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .judge_start(judge_start),
    .judge_width(judge_width), .judge_square(judge_square), .judge_dready(judge_dready),
    .rate(rate), .min_width(min_width), .is_digital(is_digital), .valid(valid),
    .busy(busy), .timeout_err(timeout_err));

  always #5 clk = ~clk;

  // Negedges until judge_start is seen; -1 if the bound expires.
  task automatic wait_start(input int max_cyc, output int cyc);
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!judge_start && cyc < max_cyc);
    if (!judge_start) cyc = -1;
  endtask

  task automatic wait_valid(input int max_cyc, output int cyc);
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!valid && cyc < max_cyc);
    if (!valid) cyc = -1;
  endtask

  // Called at the negedge showing judge_start; answers 3 cycles later, returns 1 negedge after the strobe.
  task automatic do_round(input bit sq, input logic [17:0] w);
    repeat (3) @(negedge clk);
    judge_dready = 1'b1; judge_square = sq; judge_width = w;
    @(negedge clk);
    judge_dready = 1'b0; judge_square = 1'b0; judge_width = '1;
  endtask

  // Four rounds; a stray strobe lands in the first GAP when requested.
  task automatic run_rounds(input bit sq[4], input logic [17:0] w[4], input bit stray,
                            output int gap_lat[3], output int vld_lat);
    int extra;
    for (int r = 0; r < 4; r++) begin
      do_round(sq[r], w[r]);
      extra = 0;
      if (stray && r == 0) begin
        @(negedge clk);
        judge_dready = 1'b1; judge_square = 1'b1; judge_width = 18'd10;
        @(negedge clk);
        judge_dready = 1'b0; judge_square = 1'b0; judge_width = '1;
        extra = 2;
      end
      if (r < 3) begin
        wait_start(100, gap_lat[r]);
        if (gap_lat[r] >= 0) gap_lat[r] += extra;
      end else begin
        wait_valid(100, vld_lat);
      end
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++; if (judge_start !== 1'b0) begin errors++; $display("FAIL reset_start: got %b want 0", judge_start); end
    checks++; if (rate !== 24'd0) begin errors++; $display("FAIL reset_rate: got %0d want 0", rate); end
    checks++; if (min_width !== 18'h3FFFF) begin errors++; $display("FAIL reset_min: got %h want 3ffff", min_width); end
    checks++; if ({is_digital, valid, busy, timeout_err} !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b want 0000", {is_digital, valid, busy, timeout_err}); end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0 || judge_start !== 1'b0) begin errors++; $display("FAIL idle_hold: busy %b start %b want 0 0", busy, judge_start); end
  endtask

  task automatic test_basic;
    bit sq[4]; logic [17:0] w[4]; int g[3]; int v; int c;
    sq = '{1, 1, 1, 1}; w = '{18'd5000, 18'd4000, 18'd4500, 18'd6000};
    enable = 1'b1;
    wait_start(10, c);
    checks++; if (c != 1) begin errors++; $display("FAIL basic_first_start: got %0d want 1", c); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b want 1", busy); end
    run_rounds(sq, w, 1'b0, g, v);
    for (int i = 0; i < 3; i++) begin
      checks++; if (g[i] != GAP) begin errors++; $display("FAIL basic_gap%0d: got %0d want %0d", i, g[i], GAP); end
    end
    checks++; if (v != 32) begin errors++; $display("FAIL basic_valid_lat: got %0d want 32", v); end
    checks++; if (rate !== 24'd12500) begin errors++; $display("FAIL basic_rate: got %0d want 12500", rate); end
    checks++; if (min_width !== 18'd4000) begin errors++; $display("FAIL basic_min: got %0d want 4000", min_width); end
    checks++; if (is_digital !== 1'b1 || timeout_err !== 1'b0) begin errors++; $display("FAIL basic_flags: dig %b err %b want 1 0", is_digital, timeout_err); end
    @(negedge clk);
    checks++; if (valid !== 1'b0 || judge_start !== 1'b1) begin errors++; $display("FAIL basic_b2b: valid %b start %b want 0 1", valid, judge_start); end
  endtask

  task automatic test_mixed;
    bit sq[4]; logic [17:0] w[4]; int g[3]; int v;
    sq = '{1, 0, 1, 0}; w = '{18'd3000, 18'd100, 18'd5000, 18'd100};
    run_rounds(sq, w, 1'b1, g, v);
    checks++; if (g[0] != GAP) begin errors++; $display("FAIL mixed_gap_stray: got %0d want %0d", g[0], GAP); end
    checks++; if (v != 32) begin errors++; $display("FAIL mixed_valid_lat: got %0d want 32", v); end
    checks++; if (rate !== 24'd0) begin errors++; $display("FAIL mixed_rate: got %0d want 0", rate); end
    checks++; if (min_width !== 18'd3000) begin errors++; $display("FAIL mixed_min: got %0d want 3000", min_width); end
    checks++; if (is_digital !== 1'b0) begin errors++; $display("FAIL mixed_dig: got %b want 0", is_digital); end
    @(negedge clk);
    checks++; if (judge_start !== 1'b1) begin errors++; $display("FAIL mixed_b2b: got %b want 1", judge_start); end
  endtask

  task automatic test_timeout;
    int c;
    do_round(1'b1, 18'd5000);
    wait_start(100, c);
    checks++; if (c != GAP) begin errors++; $display("FAIL tmo_gap1: got %0d want %0d", c, GAP); end
    wait_start(TMO + GAP + 50, c);
    checks++; if (c != TMO + GAP) begin errors++; $display("FAIL tmo_restart: got %0d want %0d", c, TMO + GAP); end
    do_round(1'b1, 18'd5000);
    wait_start(100, c);
    do_round(1'b1, 18'd5000);
    wait_valid(100, c);
    checks++; if (c != 32) begin errors++; $display("FAIL tmo_valid_lat: got %0d want 32", c); end
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL tmo_err: got %b want 1", timeout_err); end
    checks++; if (rate !== 24'd10000) begin errors++; $display("FAIL tmo_rate: got %0d want 10000", rate); end
    checks++; if (is_digital !== 1'b1) begin errors++; $display("FAIL tmo_dig: got %b want 1", is_digital); end
    @(negedge clk);
    checks++; if (judge_start !== 1'b1) begin errors++; $display("FAIL tmo_b2b: got %b want 1", judge_start); end
  endtask

  task automatic test_saturate;
    bit sq[4]; logic [17:0] w[4]; int g[3]; int v;
    sq = '{1, 1, 1, 1}; w = '{18'd1, 18'd1, 18'd1, 18'd1};
    run_rounds(sq, w, 1'b0, g, v);
    checks++; if (rate !== 24'hFFFFFF) begin errors++; $display("FAIL sat_rate: got %h want ffffff", rate); end
    checks++; if (min_width !== 18'd1 || timeout_err !== 1'b0) begin errors++; $display("FAIL sat_min_err: min %0d err %b want 1 0", min_width, timeout_err); end
    @(negedge clk);
    checks++; if (judge_start !== 1'b1) begin errors++; $display("FAIL sat_b2b: got %b want 1", judge_start); end
  endtask

  task automatic test_enable_drop;
    int c;
    for (int r = 0; r < 4; r++) begin
      do_round(1'b1, 18'h3FFFF);
      if (r == 0) enable = 1'b0;
      if (r < 3) wait_start(100, c); else wait_valid(100, c);
      checks++; if (c != (r < 3 ? GAP : 32)) begin errors++; $display("FAIL drop_lat%0d: got %0d want %0d", r, c, (r < 3 ? GAP : 32)); end
    end
    checks++; if (rate !== 24'd0 || is_digital !== 1'b1) begin errors++; $display("FAIL ones_result: rate %0d dig %b want 0 1", rate, is_digital); end
    checks++; if (min_width !== 18'h3FFFF) begin errors++; $display("FAIL ones_min: got %h want 3ffff", min_width); end
    @(negedge clk);
    checks++; if (busy !== 1'b0 || valid !== 1'b0) begin errors++; $display("FAIL drop_idle: busy %b valid %b want 0 0", busy, valid); end
    wait_start(40, c);
    checks++; if (c != -1) begin errors++; $display("FAIL drop_no_start: start after %0d want none", c); end
  endtask

  task automatic test_reset_mid;
    int c;
    enable = 1'b1;
    wait_start(10, c);
    checks++; if (c != 1) begin errors++; $display("FAIL mid_first_start: got %0d want 1", c); end
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if ({is_digital, busy, valid, judge_start, timeout_err} !== 5'b0) begin errors++; $display("FAIL mid_reset_flags: got %b want 00000", {is_digital, busy, valid, judge_start, timeout_err}); end
    checks++; if (rate !== 24'd0 || min_width !== 18'h3FFFF) begin errors++; $display("FAIL mid_reset_data: rate %0d min %h want 0 3ffff", rate, min_width); end
    @(negedge clk);
    rst_n = 1'b1;
    wait_start(10, c);
    checks++; if (c != 1) begin errors++; $display("FAIL mid_restart: got %0d want 1", c); end
    enable = 1'b0;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_mixed;
    test_timeout;
    test_saturate;
    test_enable_drop;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
